// File: rtl/otter_timer_pkg.sv
// Shared definitions for the OTTER IOBUS timer peripheral.
//   - Register offsets inside the 4-word window (byte offsets, bits [3:0]).
//   - CTRL field positions and a packed struct view of CTRL.
//   - Helpers that convert between the CTRL struct and its 32-bit bus image.
package otter_timer_pkg;

  localparam logic [3:0] OFS_CTRL  = 4'h0;
  localparam logic [3:0] OFS_TERM  = 4'h4;
  localparam logic [3:0] OFS_COUNT = 4'h8;
  localparam logic [3:0] OFS_STAT  = 4'hC;

  localparam int EN_BIT    = 0;
  localparam int AUTO_BIT  = 1;
  localparam int PRESC_LSB = 8;
  localparam int PRESC_MSB = 15;

  typedef struct packed {
    logic [7:0] presc;     // tick every presc+1 cycles
    logic       auto_rld;  // 1: periodic, 0: one-shot (EN clears at terminal)
    logic       en;        // counting enabled
  } ctrl_t;

  // Bus image of CTRL; unimplemented bits read as 0.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w                      = '0;
    w[EN_BIT]              = c.en;
    w[AUTO_BIT]            = c.auto_rld;
    w[PRESC_MSB:PRESC_LSB] = c.presc;
    return w;
  endfunction

  function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
    ctrl_t c;
    c.en       = w[EN_BIT];
    c.auto_rld = w[AUTO_BIT];
    c.presc    = w[PRESC_MSB:PRESC_LSB];
    return c;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the OTTER IOBUS timer.
//   CLK   : system clock
//   RST_N : synchronous active-low reset
//   en    : count enable; while low the counter sits at 0
//   clr   : force the counter back to 0 (any CTRL write)
//   presc : terminal value of the 8-bit counter
//   tick  : high in the cycle the counter equals presc while enabled
module timer_prescaler
  import otter_timer_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] r_pc;
  logic       w_at_term;

  assign w_at_term = (r_pc == presc);
  assign tick      = en & w_at_term;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc <= 8'd0;
    end else if (clr || !en || w_at_term) begin
      r_pc <= 8'd0;
    end else begin
      r_pc <= r_pc + 8'd1;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped timer/counter on the OTTER IOBUS, driving the core's INTR.
//   CLK, RST_N  : clock, synchronous active-low reset
//   IOBUS_ADDR  : bus address (window of 4 words at BASE_ADDR, [1:0] ignored)
//   IOBUS_OUT   : write data
//   IOBUS_WR    : write strobe
//   IOBUS_IN    : read data of the addressed register, 0 on a miss
//   HIT         : address falls inside this window
//   INTR        : one-cycle pulse the cycle after a terminal tick
// Registers: +0 CTRL {PRESC[15:8], AUTO[1], EN[0]}, +4 TERM, +8 COUNT,
// +C STATUS {PEND[0]} (write 1 to clear).
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_00D0,
  parameter int          CNT_W     = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        HIT,
  output logic        INTR
);
  import otter_timer_pkg::*;

  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_term;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;
  logic             r_intr;

  logic [3:0]  w_ofs;
  logic        w_hit;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_term;
  logic        w_wr_count;
  logic        w_wr_stat;
  ctrl_t       w_ctrl_wdata;
  logic        w_tick;
  logic        w_tick_evt;
  logic        w_term_evt;
  logic [31:0] w_rdata;

  // Byte lanes are masked off so every register is word-addressed.
  assign w_ofs        = IOBUS_ADDR[3:0] & 4'hC;
  assign w_hit        = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign w_wr         = IOBUS_WR & w_hit;
  assign w_wr_ctrl    = w_wr && (w_ofs == OFS_CTRL);
  assign w_wr_term    = w_wr && (w_ofs == OFS_TERM);
  assign w_wr_count   = w_wr && (w_ofs == OFS_COUNT);
  assign w_wr_stat    = w_wr && (w_ofs == OFS_STAT);
  assign w_ctrl_wdata = word_to_ctrl(IOBUS_OUT);

  timer_prescaler u_presc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (r_ctrl.en),
    .clr   (w_wr_ctrl),
    .presc (r_ctrl.presc),
    .tick  (w_tick)
  );

  // A tick is ignored when firmware overwrites COUNT in the same cycle, or
  // when a CTRL write is turning the timer off: the write always wins.
  assign w_tick_evt = w_tick && !w_wr_count && !(w_wr_ctrl && !w_ctrl_wdata.en);
  assign w_term_evt = w_tick_evt && (r_count == r_term);

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_ofs)
        OFS_CTRL:  w_rdata = ctrl_to_word(r_ctrl);
        OFS_TERM:  w_rdata = 32'(r_term);
        OFS_COUNT: w_rdata = 32'(r_count);
        OFS_STAT:  w_rdata = {31'd0, r_pend};
        default:   w_rdata = '0;
      endcase
    end
  end

  assign IOBUS_IN = w_rdata;
  assign HIT      = w_hit;
  assign INTR     = r_intr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ctrl  <= '0;
      r_term  <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_intr  <= 1'b0;
    end else begin
      r_intr <= w_term_evt;

      // A CTRL write beats the one-shot auto-disable.
      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_wdata;
      end else if (w_term_evt && !r_ctrl.auto_rld) begin
        r_ctrl.en <= 1'b0;
      end

      if (w_wr_term) begin
        r_term <= IOBUS_OUT[CNT_W-1:0];
      end

      if (w_wr_count) begin
        r_count <= IOBUS_OUT[CNT_W-1:0];
      end else if (w_term_evt) begin
        r_count <= '0;
      end else if (w_tick_evt) begin
        r_count <= r_count + CNT_W'(1);
      end

      // Setting PEND beats a simultaneous write-1-to-clear.
      if (w_term_evt) begin
        r_pend <= 1'b1;
      end else if (w_wr_stat && IOBUS_OUT[0]) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: one task per scenario,
// expectations queued in exp_q when stimulus is applied and popped when the
// DUT output is sampled (negedge, after the rising edge has settled).
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_00D0;

  logic        CLK;
  logic        RST_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        HIT;
  logic        INTR;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  otter_iobus_timer #(
    .BASE_ADDR (BASE),
    .CNT_W     (32)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .HIT        (HIT),
    .INTR       (INTR)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // All drivers are entered and left at a falling edge.
  task automatic do_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IOBUS_ADDR = BASE + 32'($urandom_range(0, 31));
      IOBUS_OUT  = $urandom;
      IOBUS_WR   = 1'($urandom_range(0, 1));
      @(posedge CLK);
      @(negedge CLK);
    end
    IOBUS_WR = 1'b0;
    RST_N    = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
    IOBUS_ADDR = addr;
    #1;
    data = IOBUS_IN;
    hit  = HIT;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e || h !== 1'b1) begin
        n_err++; $display("FAIL reset_reg%0d: got %h hit %b, want %h hit 1", i, rd, h, e);
      end
    end
    n_cmp++;
    if (INTR !== 1'b0) begin n_err++; $display("FAIL reset_intr: got %b want 0", INTR); end
    // Just past the window: no hit, reads 0.
    exp_q.push_back(32'h0);
    bus_read(BASE + 32'h10, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e || h !== 1'b0) begin
      n_err++; $display("FAIL miss_read: got %h hit %b, want %h hit 0", rd, h, e);
    end
    // Out-of-window write aliasing TERM's offset must be ignored.
    bus_write(BASE + 32'h14, 32'h0000_0055);
    exp_q.push_back(32'h0);
    bus_read(BASE + 32'h4, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL miss_write: TERM got %h want %h", rd, e); end
    // CTRL keeps only its implemented bits; byte offset ignored on read.
    bus_write(BASE, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_FF03);
    bus_read(BASE + 32'h2, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL ctrl_mask: got %h want %h", rd, e); end
  endtask

  task automatic test_periodic();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    bus_write(BASE + 32'h4, 32'd3);
    bus_write(BASE, 32'h0000_0103);
    // Tick every 2 cycles, 4 counts per period -> INTR every 8 cycles.
    for (int k = 1; k <= 24; k++) begin
      exp_q.push_back(32'(k % 8 == 0));
      exp_q.push_back(32'((k / 2) % 4));
      exp_q.push_back(32'(k >= 8));
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (INTR !== e[0]) begin n_err++; $display("FAIL periodic_intr k=%0d: got %b want %b", k, INTR, e[0]); end
      bus_read(BASE + 32'h8, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL periodic_count k=%0d: got %h want %h", k, rd, e); end
      bus_read(BASE + 32'hC, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL periodic_pend k=%0d: got %h want %h", k, rd, e); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    bus_write(BASE + 32'h4, 32'd2);
    bus_write(BASE, 32'h0000_0001);
    for (int k = 1; k <= 23; k++) begin
      exp_q.push_back(32'(k == 3));
      exp_q.push_back((k < 3) ? 32'(k) : 32'd0);
    end
    for (int k = 1; k <= 23; k++) begin
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (INTR !== e[0]) begin n_err++; $display("FAIL oneshot_intr k=%0d: got %b want %b", k, INTR, e[0]); end
      bus_read(BASE + 32'h8, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL oneshot_count k=%0d: got %h want %h", k, rd, e); end
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    bus_read(BASE, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL oneshot_ctrl: got %h want %h", rd, e); end
    bus_read(BASE + 32'hC, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL oneshot_pend: got %h want %h", rd, e); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    bus_write(BASE + 32'h4, 32'd0);
    bus_write(BASE, 32'h0000_0003);
    // PRESC=0, TERM=0: terminal every cycle, INTR held high.
    for (int k = 1; k <= 2; k++) exp_q.push_back(32'h1);
    for (int k = 1; k <= 2; k++) begin
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (INTR !== e[0]) begin n_err++; $display("FAIL w1c_intr_run k=%0d: got %b want %b", k, INTR, e[0]); end
    end
    bus_write(BASE + 32'hC, 32'h1);
    exp_q.push_back(32'h1);
    bus_read(BASE + 32'hC, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL w1c_race_pend: got %h want %h", rd, e); end
    // Disabling write coincides with a terminal tick: no INTR follows.
    bus_write(BASE, 32'h0000_0000);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (INTR !== e[0]) begin n_err++; $display("FAIL w1c_disable_intr: got %b want %b", INTR, e[0]); end
    bus_write(BASE + 32'hC, 32'h1);
    exp_q.push_back(32'h0);
    bus_read(BASE + 32'hC, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL w1c_clear_pend: got %h want %h", rd, e); end
  endtask

  task automatic test_count_write();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    bus_write(BASE + 32'h4, 32'd5);
    bus_write(BASE, 32'h0000_0003);
    for (int k = 1; k <= 2; k++) exp_q.push_back(32'(k));
    for (int k = 1; k <= 2; k++) begin
      step();
      bus_read(BASE + 32'h8, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL cw_run_count k=%0d: got %h want %h", k, rd, e); end
    end
    bus_write(BASE + 32'h8, 32'd5);
    // After write: {intr, count} = 0/5; next: 1/0; next: 0/1.
    exp_q.push_back(32'h0); exp_q.push_back(32'd5);
    exp_q.push_back(32'h1); exp_q.push_back(32'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) step();
      e = exp_q.pop_front(); n_cmp++;
      if (INTR !== e[0]) begin n_err++; $display("FAIL cw_term_intr k=%0d: got %b want %b", k, INTR, e[0]); end
      bus_read(BASE + 32'h8, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL cw_term_count k=%0d: got %h want %h", k, rd, e); end
    end
    // Tick is active every cycle here; the written value must win.
    bus_write(BASE + 32'h8, 32'd2);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    bus_read(BASE + 32'h8, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL cw_tick_count: got %h want %h", rd, e); end
    step();
    bus_read(BASE + 32'h8, rd, h);
    e = exp_q.pop_front(); n_cmp++;
    if (rd !== e) begin n_err++; $display("FAIL cw_after_count: got %h want %h", rd, e); end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] rd, e;
    logic        h;
    do_reset();
    bus_write(BASE + 32'h4, 32'd4);
    bus_write(BASE, 32'h0000_0001);
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
    for (int k = 1; k <= 4; k++) begin
      step();
      bus_read(BASE + 32'h8, rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL mr_count k=%0d: got %h want %h", k, rd, e); end
    end
    // COUNT==TERM now: the next edge would be terminal, but reset takes it.
    RST_N = 1'b0;
    step();
    n_cmp++;
    if (INTR !== 1'b0) begin n_err++; $display("FAIL mr_intr_at_reset: got %b want 0", INTR); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), rd, h);
      e = exp_q.pop_front(); n_cmp++;
      if (rd !== e) begin n_err++; $display("FAIL mr_reg%0d: got %h want %h", i, rd, e); end
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      e = exp_q.pop_front(); n_cmp++;
      if (INTR !== e[0]) begin n_err++; $display("FAIL mr_intr_after k=%0d: got %b want %b", k, INTR, e[0]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    RST_N      = 1'b0;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
    IOBUS_WR   = 1'b0;
    @(negedge CLK);
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c_race();
    test_count_write();
    test_midrun_reset();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
